hls_macc_arb: RTL

HLS_MACC_ARB -- requirements
Module: hls_macc_arb

---
 rtl/hls_macc_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hls_macc_arb.sv
// Two-requester round-robin front end for an HLS ap_ctrl_hs core with o1/o2 ap_vld outputs.
// Optional watchdog enabled by defining HLS_MACC_ARB_TIMEOUT_EN (uses parameter TIMEOUT).
module hls_macc_arb #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            ap_clk,
    input  logic            ap_rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [5*DW-1:0] req_data0,
    input  logic [5*DW-1:0] req_data1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_o1,
    output logic [DW-1:0]   rsp_o2,
    output logic            rsp_err,
    output logic            core_start,
    input  logic            core_ready,
    input  logic            core_done,
    input  logic            core_idle,
    output logic [5*DW-1:0] core_ops,
    input  logic [DW-1:0]   core_o1,
    input  logic            core_o1_vld,
    input  logic [DW-1:0]   core_o2,
    input  logic            core_o2_vld
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic            last_r;
    logic            win_s;
    logic [1:0]      grant_s;
    logic            hs_s;
    logic            done_now_s;
    logic            timeout_hit_s;
    logic [5*DW-1:0] ops_s;

`ifdef HLS_MACC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_r;
`endif

    // Round-robin winner selection and the IDLE-only one-hot grant.
    always_comb begin
        win_s   = 1'b0;
        grant_s = 2'b00;
        case (req_valid)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_r;
            default: win_s = 1'b0;
        endcase
        if ((state_r == ST_IDLE) && core_idle && !ap_rst && (req_valid != 2'b00)) begin
            grant_s = win_s ? 2'b10 : 2'b01;
        end else begin
            grant_s = 2'b00;
        end
    end

    assign req_ready = grant_s;
    assign hs_s      = |(req_valid & grant_s);
    assign ops_s     = win_s ? req_data1 : req_data0;

    // Completion requires ap_ready in ISSUE; in WAIT ap_ready has already been seen.
    always_comb begin
        done_now_s    = 1'b0;
        timeout_hit_s = 1'b0;
        if (state_r == ST_ISSUE) begin
            done_now_s = core_ready & core_done;
        end else begin
            done_now_s = core_done;
        end
`ifdef HLS_MACC_ARB_TIMEOUT_EN
        timeout_hit_s = (cnt_r == CW'(TIMEOUT - 1));
`else
        timeout_hit_s = 1'b0;
`endif
    end

    // Control FSM with registered handshake, core and result outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_o1     <= {DW{1'b0}};
            rsp_o2     <= {DW{1'b0}};
            core_ops   <= {(5*DW){1'b0}};
`ifdef HLS_MACC_ARB_TIMEOUT_EN
            cnt_r      <= {CW{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        core_ops   <= ops_s;
                        rsp_id     <= win_s;
                        last_r     <= win_s;
                        rsp_o1     <= {DW{1'b0}};
                        rsp_o2     <= {DW{1'b0}};
                        rsp_err    <= 1'b0;
                        core_start <= 1'b1;
                        state_r    <= ST_ISSUE;
`ifdef HLS_MACC_ARB_TIMEOUT_EN
                        cnt_r      <= {CW{1'b0}};
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (core_o1_vld) begin
                        rsp_o1 <= core_o1;
                    end
                    if (core_o2_vld) begin
                        rsp_o2 <= core_o2;
                    end
`ifdef HLS_MACC_ARB_TIMEOUT_EN
                    cnt_r <= cnt_r + CW'(1);
`endif
                    if (done_now_s) begin
                        core_start <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state_r    <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        core_start <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                        state_r    <= ST_RESP;
                    end else if ((state_r == ST_ISSUE) && core_ready) begin
                        core_start <= 1'b0;
                        state_r    <= ST_WAIT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
